sw_debounce: RTL and testbench
==============================

# sw_debounce

Debounces and synchronises the board push-buttons before they reach the MCU and LED logic on the Brevia 2 top level. Each raw switch input is two-flop synchronised, then qualified by a shared millisecond-scale tick and a per-channel stability counter. The block produces a clean level per channel plus single-cycle press and release event pulses. It sits between the board switch pins and the consumers in the top-level wrapper.

## Interface
- WIDTH, 4: number of switch channels.
- PRESCALE, 50000: clk cycles per debounce tick (1 ms at 50 MHz).
- STABLE, 16: consecutive ticks an input must disagree with the current state before the state flips; minimum 1.
- ACTIVE_LOW, 1: 1 = pin low means pressed; 0 = pin high means pressed.
- REPEAT_DELAY, 500: ticks held before the first auto-repeat (only with SW_REPEAT_EN).
- REPEAT_RATE, 100: ticks between subsequent auto-repeats (only with SW_REPEAT_EN).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- sw_in  in  WIDTH  raw switch pins, asynchronous to clk.
- state  out  WIDTH  debounced level; 1 = pressed.
- press  out  WIDTH  one-cycle pulse on a debounced press, or on an auto-repeat.
- release  out  WIDTH  one-cycle pulse on a debounced release.
- tick  out  1  one-cycle prescaler tick, exported for other slow timers.

## Operation
- **Synchroniser:** two flops per channel. Both reset to the inactive pin level (1 if ACTIVE_LOW, else 0). `act` = synchronised value converted to pressed polarity.
- **Prescaler:** counter runs 0..PRESCALE-1 and wraps to 0. `tick` = 1 during the cycle the counter equals PRESCALE-1.
- **Per-channel counter:** width $clog2(STABLE+1). States are STABLE_IDLE (act == state) and COUNTING (act != state).
  - Any cycle with act == state: counter cleared to 0.
  - Tick cycle with act != state and counter < STABLE-1: counter increments.
  - Tick cycle with act != state and counter == STABLE-1: state inverts, counter cleared, and press (new state 1) or release (new state 0) fires.
- **Bounce:** a single cycle of agreement clears the counter, so a flip needs STABLE consecutive disagreeing ticks with no agreeing cycle between them.
- **Independence:** channels are independent. Simultaneous flips on several channels all pulse in the same cycle.
- **Reset:** asynchronous and may assert mid-count. Outputs after reset: state = 0, press = 0, release = 0, tick = 0, prescaler = 0, all counters = 0.

## Timing
- Outputs are registered.
- press/release rise in the cycle after the qualifying tick cycle, together with the state change, and last exactly 1 cycle.
- Latency from a clean, stable pin edge to the state change:
  - minimum 2 + (STABLE-1)·PRESCALE + 1 cycles
  - maximum 2 + STABLE·PRESCALE + 1 cycles
  - the spread depends on prescaler phase.
- press and release never both assert on one channel in the same cycle.

## Configuration
- **SW_REPEAT_EN defined:**
  - Each channel has a repeat counter of width $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
  - The counter is cleared whenever state is 0 and in the cycle state rises.
  - While state = 1, it increments on each tick.
  - First reaching REPEAT_DELAY: press pulses for 1 cycle and the counter reloads to REPEAT_DELAY-REPEAT_RATE.
  - Each later arrival at REPEAT_DELAY repeats this, giving one pulse every REPEAT_RATE ticks.
  - Repeats stop in the cycle release fires.
- **SW_REPEAT_EN not defined:** no repeat logic is generated. press fires only on debounced press edges. REPEAT_DELAY and REPEAT_RATE are ignored.

## Test plan
Bench parameters: PRESCALE=4, STABLE=3, ACTIVE_LOW=1, REPEAT_DELAY=5, REPEAT_RATE=2.

- **Reset:** assert rst with sw_in=4'b1111 -> state=0, press=0, release=0, tick=0 during reset. After deassertion, tick pulses every 4th cycle.
- **Clean press:** drive sw_in[0]=0 and hold -> state[0] rises 11..15 cycles after the pin edge. press[0] is high for exactly 1 cycle, coincident with the rise. Other channels stay 0.
- **Bounce:** toggle sw_in[1] every 3 cycles for 60 cycles, then hold it high -> state[1] stays 0 and no press/release pulses occur.
- **Release and simultaneity:** channels 2 and 3 pressed and stable; release both in the same cycle -> release[3:2]=2'b11 in one cycle, state[3:2] goes to 00, and press stays 0.
- **Auto-repeat (SW_REPEAT_EN):** hold sw_in[0]=0 for 12 ticks after the debounced press. Expected press pulses on channel 0:
  - debounce press
  - +5 ticks
  - +7 ticks
  - +9 ticks
  - +11 ticks
  - That is 5 total. Release then gives a release pulse and no further press.
- **Reset mid-count:** sw_in[0]=0 held for 2 ticks, then pulse rst for 1 cycle -> counter is cleared and state[0] needs a full 3 stable ticks after reset. No press pulse occurs earlier.

Source files
------------

// File: rtl/sw_debounce_if.sv
// Switch-side bundle for sw_debounce: raw pins in, debounced level and event pulses out.
// "release" is a reserved word, so the release event travels as release_pulse.
interface sw_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] release_pulse;
    logic             tick;

    modport master (output sw_in, input state, press, release_pulse, tick);
    modport slave  (input sw_in, output state, press, release_pulse, tick);
endinterface

// File: rtl/sw_debounce.sv
// Push-button debouncer: 2-flop sync, shared prescaler tick, per-channel stability counter.
// Define SW_REPEAT_EN to add hold-to-repeat press pulses.
module sw_debounce #(
    parameter int WIDTH        = 4,
    parameter int PRESCALE     = 50000,
    parameter int STABLE       = 16,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic         clk,
    input  logic         rst,
    sw_debounce_if.slave bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(STABLE + 1);
    localparam logic [WIDTH-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    localparam logic ST_IDLE     = 1'b0;
    localparam logic ST_COUNTING = 1'b1;

    // Repeat settings are checked even when unused so the option can be toggled safely.
    if (STABLE < 1 || PRESCALE < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_cfg
        $error("sw_debounce: illegal parameter combination");
    end

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] act;
    logic [WIDTH-1:0] phase;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] rpt_fire;
    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] press_r;
    logic [WIDTH-1:0] release_r;
    logic [PW-1:0]    pre_cnt;
    logic [PW-1:0]    pre_next;
    logic             tick_r;
    logic [CW-1:0]    cnt [WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= INACTIVE;
            sync2 <= INACTIVE;
        end else begin
            sync1 <= bus.sw_in;
            sync2 <= sync1;
        end
    end

    assign act      = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    assign pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);

    // tick is registered from the next count so it is high exactly while pre_cnt == PRESCALE-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            tick_r  <= 1'b0;
        end else begin
            pre_cnt <= pre_next;
            tick_r  <= (pre_next == PRE_LAST);
        end
    end

    always_comb begin
        phase = '0;
        flip  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            phase[i] = (act[i] != state_r[i]) ? ST_COUNTING : ST_IDLE;
            flip[i]  = tick_r && (phase[i] == ST_COUNTING) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (phase[i] == ST_IDLE || flip[i]) cnt[i] <= '0;
                else if (tick_r)                    cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

`ifdef SW_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

    logic [RW-1:0] rpt [WIDTH];

    // A repeat never coincides with a release flip, so press and release stay exclusive.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rpt_fire[i] = tick_r && state_r[i] && !flip[i] && (rpt[i] == RPT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) rpt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!state_r[i])              rpt[i] <= '0;
                else if (tick_r) begin
                    if (rpt[i] == RPT_LAST)   rpt[i] <= RPT_RELOAD;
                    else                      rpt[i] <= rpt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= '0;
            press_r   <= '0;
            release_r <= '0;
        end else begin
            state_r   <= state_r ^ flip;
            press_r   <= (flip & ~state_r) | rpt_fire;
            release_r <= flip & state_r;
        end
    end

    assign bus.state         = state_r;
    assign bus.press         = press_r;
    assign bus.release_pulse = release_r;
    assign bus.tick          = tick_r;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: directed scenarios plus random pin activity,
// checked against a timestamp-based reference model (honours SW_REPEAT_EN).
module tb_sw_debounce;

    localparam int WIDTH        = 4;
    localparam int PRESCALE     = 4;
    localparam int STABLE       = 3;
    localparam int ACTIVE_LOW   = 1;
    localparam int REPEAT_DELAY = 5;
    localparam int REPEAT_RATE  = 2;
`ifdef SW_REPEAT_EN
    localparam int EXP_HOLD_PRESSES = 5;
`else
    localparam int EXP_HOLD_PRESSES = 1;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] state;
        logic [WIDTH-1:0] press;
        logic [WIDTH-1:0] rel;
        logic             tick;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sw_debounce_if #(.WIDTH(WIDTH)) bus ();

    sw_debounce #(
        .WIDTH(WIDTH), .PRESCALE(PRESCALE), .STABLE(STABLE), .ACTIVE_LOW(ACTIVE_LOW),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_state;
    int               run_start [WIDTH];
    int               press_edge [WIDTH];
    int               edge_num;
    bit               live = 1'b0;
    int               vectors = 0;
    int               miscompares = 0;
    int               press_seen [WIDTH];
    int               release_seen [WIDTH];

    // Model: a flip happens on the tick where the current unbroken disagreement run
    // has seen STABLE ticks; act lags the sampled pin by two edges.
    function automatic void modelReset();
        edge_num = 0;
        m_state  = '0;
        exp_q.delete();
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        for (int c = 0; c < WIDTH; c++) begin
            run_start[c]  = 0;
            press_edge[c] = 0;
        end
    endfunction

    function automatic exp_t modelStep(input logic [WIDTH-1:0] sw);
        exp_t             e;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] old;
        bit               is_tick;
        int               m;
        edge_num++;
        hist.push_back((ACTIVE_LOW != 0) ? ~sw : sw);
        a       = hist.pop_front();
        is_tick = (edge_num % PRESCALE) == 0;
        old     = m_state;
        e       = '0;
        for (int c = 0; c < WIDTH; c++) begin
            if (a[c] == old[c]) begin
                run_start[c] = 0;
            end else begin
                if (run_start[c] == 0) run_start[c] = edge_num;
                if (is_tick && (edge_num / PRESCALE - (run_start[c] - 1) / PRESCALE) == STABLE) begin
                    m_state[c]   = ~old[c];
                    run_start[c] = 0;
                    if (m_state[c]) begin
                        e.press[c]    = 1'b1;
                        press_edge[c] = edge_num;
                    end else begin
                        e.rel[c] = 1'b1;
                    end
                end
            end
`ifdef SW_REPEAT_EN
            if (old[c] && m_state[c] && is_tick) begin
                m = (edge_num - press_edge[c]) / PRESCALE;
                if (m >= REPEAT_DELAY && (m - REPEAT_DELAY) % REPEAT_RATE == 0) e.press[c] = 1'b1;
            end
`endif
        end
        e.state = m_state;
        e.tick  = (edge_num % PRESCALE) == PRESCALE - 1;
        return e;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] sw);
        bus.sw_in = sw;
        exp_q.push_back(modelStep(sw));
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input exp_t exp_v);
        exp_t got;
        got = {bus.state, bus.press, bus.release_pulse, bus.tick};
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s edge=%0d state=%b/%b press=%b/%b release=%b/%b tick=%b/%b (got/expected)",
                     name, edge_num, got.state, exp_v.state, got.press, exp_v.press,
                     got.rel, exp_v.rel, got.tick, exp_v.tick);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int lo, input int hi);
        vectors++;
        if (got < lo || got > hi) begin
            miscompares++;
            $display("[TB] FAIL %s got=%0d expected=%0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic doReset(input int cycles, input logic [WIDTH-1:0] sw);
        live      = 1'b0;
        rst       = 1'b1;
        bus.sw_in = sw;
        #1;
        checkOutput("reset_outputs", '0);
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        modelReset();
        live = 1'b1;
    endtask

    task automatic clearTallies();
        for (int c = 0; c < WIDTH; c++) begin
            press_seen[c]   = 0;
            release_seen[c] = 0;
        end
    endtask

    // Monitor: pops one expectation per live clock edge and tallies observed pulses.
    always @(posedge clk) begin
        #1;
        if (live && !rst) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL scoreboard_empty edge=%0d got=none expected=entry", edge_num);
            end else begin
                checkOutput("outputs", exp_q.pop_front());
            end
            for (int c = 0; c < WIDTH; c++) begin
                press_seen[c]   += int'(bus.press[c]);
                release_seen[c] += int'(bus.release_pulse[c]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int               n;
        logic [WIDTH-1:0] cur;
        int               toggle_div;
        bus.sw_in = '1;
        clearTallies();
        @(negedge clk);
        doReset(3, 4'b1111);
        repeat (8) applyStimulus(4'b1111);

        // Clean press on channel 0, then hold long enough for repeats, then release.
        clearTallies();
        n = 0;
        do begin
            applyStimulus(4'b1110);
            n++;
        end while (bus.state[0] !== 1'b1 && n < 40);
        checkValue("press_latency", n, 11, 15);
        repeat (40) applyStimulus(4'b1110);
        repeat (24) applyStimulus(4'b1111);
        checkValue("hold_press_count", press_seen[0], EXP_HOLD_PRESSES, EXP_HOLD_PRESSES);
        checkValue("hold_release_count", release_seen[0], 1, 1);

        // Bounce on channel 1 never survives long enough to flip.
        clearTallies();
        cur = 4'b1111;
        for (int k = 0; k < 60; k++) begin
            if (k % 3 == 0) cur[1] = ~cur[1];
            applyStimulus(cur);
        end
        repeat (20) applyStimulus(4'b1111);
        checkValue("bounce_press_count", press_seen[1], 0, 0);

        // Channels 2 and 3 pressed and released together.
        clearTallies();
        repeat (20) applyStimulus(4'b0011);
        repeat (20) applyStimulus(4'b1111);
        checkValue("simul_release_ch2", release_seen[2], 1, 1);
        checkValue("simul_release_ch3", release_seen[3], 1, 1);

        // Reset mid-count: the partial count is lost and debouncing restarts.
        repeat (8) applyStimulus(4'b1110);
        doReset(1, 4'b1110);
        clearTallies();
        n = 0;
        do begin
            applyStimulus(4'b1110);
            n++;
        end while (bus.state[0] !== 1'b1 && n < 40);
        checkValue("post_reset_latency", n, 11, 15);
        checkValue("post_reset_press_count", press_seen[0], 1, 1);
        repeat (20) applyStimulus(4'b1111);

        // Random pin activity alternating between bouncy and calm phases.
        cur        = 4'b1111;
        toggle_div = 20;
        for (int k = 0; k < 1500; k++) begin
            if (k % 100 == 0) toggle_div = ($urandom_range(0, 2) == 0) ? 3 : 25;
            for (int c = 0; c < WIDTH; c++) begin
                if ($urandom_range(0, toggle_div - 1) == 0) cur[c] = ~cur[c];
            end
            if ($urandom_range(0, 599) == 0) doReset(1 + $urandom_range(0, 2), cur);
            else                             applyStimulus(cur);
        end

        live = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
